// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: one FSM steps a shared ALU and a single unified
// req/ready memory port. Illegal opcode or funct parks the core in a halted trap state.
module mips_multicycle_core #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter bit                REG_CLR  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted
);

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpOri  = 6'b001101;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StWbR, StExecI, StWbI, StAddr,
    StMemRd, StWbMem, StMemWr, StBranch, StJump, StTrap
  } state_e;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q, a_q, b_q, aluout_q, mdr_q;
  logic [31:0]       rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] sext_imm, zext_imm, rs_val, rt_val, pc_ext;
  logic        funct_ok;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'd0, imm};
  assign pc_ext   = 32'(pc_q);
  assign funct_ok = funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt};

  assign rs_val = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf[rt];

  // Shared ALU: operand selection depends on which step is running.
  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_e     alu_op;

  always_comb begin
    alu_a  = a_q;
    alu_b  = sext_imm;
    alu_op = AluAdd;
    case (state_q)
      StFetch: begin
        alu_a = pc_ext;
        alu_b = 32'd4;
      end
      StDecode: begin
        alu_a = pc_ext;
        alu_b = {sext_imm[29:0], 2'b00};
      end
      StExecR: begin
        alu_b = b_q;
        case (funct)
          FnSub:   alu_op = AluSub;
          FnAnd:   alu_op = AluAnd;
          FnOr:    alu_op = AluOr;
          FnSlt:   alu_op = AluSlt;
          default: alu_op = AluAdd;
        endcase
      end
      StExecI: begin
        if (opcode == OpOri) begin
          alu_b  = zext_imm;
          alu_op = AluOr;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      AluSub:  alu_y = alu_a - alu_b;
      AluAnd:  alu_y = alu_a & alu_b;
      AluOr:   alu_y = alu_a | alu_b;
      AluSlt:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  // Jump keeps PC bits above the 28-bit region; narrow PCs take only the low bits.
  logic [ADDR_W-1:0] jmask, jump_pc, addr_sel;
  assign jmask   = ADDR_W'(28'hFFF_FFFF);
  assign jump_pc = (pc_q & ~jmask) | ADDR_W'({ir_q[25:0], 2'b00});

  assign addr_sel  = (state_q == StFetch) ? pc_q : aluout_q[ADDR_W-1:0];
  assign mem_addr  = {addr_sel[ADDR_W-1:2], 2'b00};
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign halted    = (state_q == StTrap);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpR:           state_d = StExecR;
          OpLw, OpSw:    state_d = StAddr;
          OpBeq:         state_d = StBranch;
          OpJ:           state_d = StJump;
          OpAddi, OpOri: state_d = StExecI;
          default:       state_d = StTrap;
        endcase
      end
      StExecR:  state_d = funct_ok ? StWbR : StTrap;
      StExecI:  state_d = StWbI;
      StAddr:   state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StWbMem;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StWbR, StWbI, StWbMem, StBranch, StJump: state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase
  end

  // FSM outputs; reset gates them so a mid-access reset drops the request at once.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      StFetch, StMemRd: mem_req = 1'b1;
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        retire  = mem_ready;
      end
      StWbR, StWbI, StWbMem, StBranch, StJump: retire = 1'b1;
      default: ;
    endcase
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          if (mem_ready) begin
            ir_q <= mem_rdata;
            pc_q <= alu_y[ADDR_W-1:0];
          end
        end
        StDecode: begin
          a_q      <= rs_val;
          b_q      <= rt_val;
          aluout_q <= alu_y;
        end
        StExecR:         if (funct_ok) aluout_q <= alu_y;
        StExecI, StAddr: aluout_q <= alu_y;
        StMemRd:         if (mem_ready) mdr_q <= mem_rdata;
        StBranch:        if (a_q == b_q) pc_q <= aluout_q[ADDR_W-1:0];
        StJump:          pc_q <= jump_pc;
        default: ;
      endcase
    end
  end

  // Register file write port
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  always_comb begin
    rf_we = 1'b0;
    rf_wa = rt;
    rf_wd = aluout_q;
    case (state_q)
      StWbR: begin
        rf_we = 1'b1;
        rf_wa = rd;
      end
      StWbI:   rf_we = 1'b1;
      StWbMem: begin
        rf_we = 1'b1;
        rf_wd = mdr_q;
      end
      default: ;
    endcase
  end

  if (REG_CLR) begin : g_rf_clr
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (rf_we && rf_wa != 5'd0) begin
        rf[rf_wa] <= rf_wd;
      end
    end
  end else begin : g_rf_keep
    always_ff @(posedge clk) begin
      if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core: expected retires and stores are queued
// by the stimulus and popped by a monitor as the core presents them.
module tb_mips_multicycle_core;

  logic        clk, reset;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  mips_multicycle_core dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .retire    (retire),
    .halted    (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: image copied in while reset is high; some regions insert 3 wait states.
  logic [31:0] mem [1024];
  logic [31:0] img [1024];
  int unsigned wcnt;

  function automatic int unsigned lat(input logic [31:0] a);
    if ((a >= 32'h80 && a < 32'hC0) || (a >= 32'h300 && a < 32'h400)) return 3;
    return 0;
  endfunction

  assign mem_rdata = mem[mem_addr[11:2]];
  assign mem_ready = mem_req && (wcnt >= lat(mem_addr));

  always @(posedge clk) begin
    if (reset) begin
      mem  <= img;
      wcnt <= 0;
    end else begin
      if (mem_req && mem_we && mem_ready) mem[mem_addr[11:2]] <= mem_wdata;
      if (!mem_req || mem_ready) wcnt <= 0;
      else                       wcnt <= wcnt + 1;
    end
  end

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } ret_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  ret_t ret_q[$];
  wr_t  wr_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic pc_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_ret(input logic [31:0] p, input int c);
    ret_t r;
    r.pc  = p;
    r.cyc = c;
    ret_q.push_back(r);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic put(input int unsigned a, input logic [31:0] w);
    img[a >> 2] = w;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = 32'h0;
  endtask

  // Monitor: cycle counting, retire/store scoreboard, request stability during waits.
  initial begin
    int          cyc;
    logic [31:0] pc_exp, s_addr, s_wdata;
    logic        s_we, stab_v;
    ret_t        r;
    wr_t         w;
    cyc    = 0;
    stab_v = 1'b0;
    pc_exp = '0;
    s_addr = '0;
    s_wdata = '0;
    s_we   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc     = 0;
        pc_pend = 1'b0;
        stab_v  = 1'b0;
      end else begin
        cyc++;
        if (pc_pend) begin
          chk("pc_after_retire", pc, pc_exp);
          pc_pend = 1'b0;
        end
        if (stab_v && mem_req) begin
          chk("hold_addr", mem_addr, s_addr);
          chk("hold_we", 32'(mem_we), 32'(s_we));
          if (s_we) chk("hold_wdata", mem_wdata, s_wdata);
        end
        stab_v  = mem_req && !mem_ready;
        s_addr  = mem_addr;
        s_we    = mem_we;
        s_wdata = mem_wdata;
        if (mem_req && mem_we && mem_ready) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_store_addr", mem_addr, 32'hFFFF_FFFF);
          end else begin
            w = wr_q.pop_front();
            chk("store_addr", mem_addr, w.addr);
            chk("store_data", mem_wdata, w.data);
          end
        end
        if (retire) begin
          if (ret_q.size() == 0) begin
            chk("unexpected_retire_pc", pc, 32'hFFFF_FFFF);
          end else begin
            r = ret_q.pop_front();
            chk("retire_cycles", 32'(cyc), 32'(r.cyc));
            pc_exp  = r.pc;
            pc_pend = 1'b1;
          end
          cyc = 0;
        end
      end
    end
  end

  task automatic wait_drain(input int maxc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk);
      #1;
      if (ret_q.size() == 0 && wr_q.size() == 0 && !pc_pend) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d retires and %0d stores still expected",
               ret_q.size(), wr_q.size());
    end
  endtask

  task automatic wait_halt(input string name, input int exp_cyc);
    int n;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      #1;
      if (halted) n = i;
    end
    chk(name, 32'(n), 32'(exp_cyc));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_img();
    // ALU and immediate block, then stores of every result
    put(32'h00, 32'h20010005);  // addi $1,$0,5
    put(32'h04, 32'h20020007);  // addi $2,$0,7
    put(32'h08, 32'h00221820);  // add  $3,$1,$2
    put(32'h0C, 32'h00222022);  // sub  $4,$1,$2
    put(32'h10, 32'h0022282A);  // slt  $5,$1,$2
    put(32'h14, 32'h00220020);  // add  $0,$1,$2
    put(32'h18, 32'h34078001);  // ori  $7,$0,0x8001
    put(32'h1C, 32'h2008FFFD);  // addi $8,$0,-3
    put(32'h20, 32'h00224824);  // and  $9,$1,$2
    put(32'h24, 32'h00225025);  // or   $10,$1,$2
    put(32'h28, 32'h0101582A);  // slt  $11,$8,$1
    put(32'h2C, 32'h0028602A);  // slt  $12,$1,$8
    put(32'h30, 32'hAC040200);
    put(32'h34, 32'hAC050204);
    put(32'h38, 32'hAC000208);
    put(32'h3C, 32'hAC07020C);
    put(32'h40, 32'hAC080210);
    put(32'h44, 32'hAC090214);
    put(32'h48, 32'hAC0A0218);
    put(32'h4C, 32'hAC0B021C);
    put(32'h50, 32'hAC0C0220);
    put(32'h54, 32'h08000020);  // j 0x80
    // wait-state region
    put(32'h80, 32'hAC030300);  // sw $3,0x300($0)
    put(32'h84, 32'h8C060300);  // lw $6,0x300($0)
    put(32'h88, 32'hAC060304);  // sw $6,0x304($0)
    put(32'h8C, 32'h08000030);  // j 0xC0
    // branches
    put(32'hC0, 32'h10220005);  // beq $1,$2,+5 (not taken)
    put(32'hC4, 32'h10210001);  // beq $1,$1,+1 (taken)
    put(32'hC8, 32'hFC000000);  // skipped
    put(32'hCC, 32'h08000040);  // j 0x40 -> 0x100
    put(32'h100, 32'h1021FFFF); // beq $1,$1,-1

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_retire", 32'(retire), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    for (int i = 1; i <= 21; i++) exp_ret(32'(4 * i), 4);
    exp_ret(32'h80, 3);
    exp_ret(32'h84, 10);
    exp_ret(32'h88, 11);
    exp_ret(32'h8C, 10);
    exp_ret(32'hC0, 6);
    exp_ret(32'hC4, 3);
    exp_ret(32'hCC, 3);
    exp_ret(32'h100, 3);
    for (int i = 0; i < 3; i++) exp_ret(32'h100, 3);
    exp_wr(32'h200, 32'hFFFF_FFFE);
    exp_wr(32'h204, 32'h1);
    exp_wr(32'h208, 32'h0);
    exp_wr(32'h20C, 32'h0000_8001);
    exp_wr(32'h210, 32'hFFFF_FFFD);
    exp_wr(32'h214, 32'h5);
    exp_wr(32'h218, 32'h7);
    exp_wr(32'h21C, 32'h1);
    exp_wr(32'h220, 32'h0);
    exp_wr(32'h300, 32'd12);
    exp_wr(32'h304, 32'd12);

    @(posedge clk);
    #2 reset = 1'b0;
    wait_drain(600);

    // Illegal opcode after one good instruction
    reset = 1'b1;
    clear_img();
    put(32'h00, 32'h20010005);
    put(32'h04, 32'hFC000000);
    exp_ret(32'h4, 4);
    do_reset();
    wait_halt("op_trap_cycle", 7);
    chk("op_trap_retired", 32'(ret_q.size()), 32'h0);
    chk("op_trap_pc", pc, 32'h8);
    chk("op_trap_req", 32'(mem_req), 32'h0);
    repeat (8) @(negedge clk);
    #1;
    chk("op_trap_pc_frozen", pc, 32'h8);
    chk("op_trap_halted_sticky", 32'(halted), 32'h1);
    chk("op_trap_req_idle", 32'(mem_req), 32'h0);

    // Illegal funct on an R-type
    reset = 1'b1;
    clear_img();
    put(32'h00, 32'h00221807);
    do_reset();
    wait_halt("fn_trap_cycle", 4);
    chk("fn_trap_pc", pc, 32'h4);
    chk("fn_trap_req", 32'(mem_req), 32'h0);
    repeat (5) @(negedge clk);
    #1;
    chk("fn_trap_pc_frozen", pc, 32'h4);

    // Reset while a store waits on memory
    reset = 1'b1;
    clear_img();
    put(32'h00, 32'hAC000300);
    do_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (mem_req && mem_we) break;
    end
    chk("mw_reached_store", 32'(mem_req && mem_we), 32'h1);
    reset = 1'b1;
    #1;
    chk("mw_rst_req", 32'(mem_req), 32'h0);
    chk("mw_rst_we", 32'(mem_we), 32'h0);
    chk("mw_rst_pc", pc, 32'h0);
    chk("mw_rst_halted", 32'(halted), 32'h0);
    clear_img();
    put(32'h00, 32'h200D0009);  // addi $13,$0,9
    put(32'h04, 32'hAC0D0208);  // sw $13,0x208($0)
    put(32'h08, 32'h1000FFFF);  // beq $0,$0,-1
    exp_ret(32'h4, 4);
    exp_ret(32'h8, 4);
    exp_ret(32'h8, 3);
    exp_ret(32'h8, 3);
    exp_wr(32'h208, 32'd9);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("restart_req", 32'(mem_req), 32'h1);
    chk("restart_we", 32'(mem_we), 32'h0);
    chk("restart_addr", mem_addr, 32'h0);
    wait_drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
